// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_buffer
//  Description : Program counter and IF/ID pipeline register. Applies PC-hold,
//                IF/ID-hold and flush controls, inserts NOP bubbles, and keeps
//                a saturating stall counter plus a sticky hold-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_buffer #(
    parameter int              SIZE     = 16,
    parameter logic [SIZE-1:0] RESET_PC = '0,
    parameter int              MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcWrite,
    input  logic            fetchWrite,
    input  logic            flush,
    input  logic [SIZE-1:0] branchTarget,
    input  logic [SIZE-1:0] instrIn,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] instrOut,
    output logic [SIZE-1:0] pcPlus2Out,
    output logic            validOut,
    output logic [1:0]      state,
    output logic [15:0]     stallCount,
    output logic            holdTimeout
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] c_PC_STEP   = SIZE'(2);
    localparam logic [7:0]      c_MAX_HOLD  = 8'(MAX_HOLD);
    localparam logic [7:0]      c_RUN_MAX   = 8'hFF;
    localparam logic [15:0]     c_STALL_MAX = 16'hFFFF;

    state_t          r_state;
    state_t          w_state_next;
    logic [SIZE-1:0] r_pc;
    logic [SIZE-1:0] r_instr;
    logic [SIZE-1:0] r_pc_plus2;
    logic            r_valid;
    logic [15:0]     r_stall_cnt;
    logic [7:0]      r_hold_run;
    logic            r_timeout;

    logic [SIZE-1:0] w_pc_plus2;
    logic            w_stall;
    logic [7:0]      w_hold_run_inc;

    // A stall cycle is a held IF/ID with no flush overriding it.
    assign w_pc_plus2     = r_pc + c_PC_STEP;
    assign w_stall        = fetchWrite & ~flush;
    assign w_hold_run_inc = (r_hold_run == c_RUN_MAX) ? c_RUN_MAX : r_hold_run + 8'd1;

    // Next-state logic: flush always forces a bubble, otherwise hold tracks fetchWrite.
    always_comb begin
        w_state_next = ST_RUN;
        case (r_state)
            ST_RUN, ST_HOLD, ST_BUBBLE: begin
                if (flush) begin
                    w_state_next = ST_BUBBLE;
                end else if (fetchWrite) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = flush ? ST_BUBBLE : ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC and IF/ID register: flush redirects and squashes, holds freeze each side independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_pc       <= branchTarget;
            r_instr    <= '0;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (!pcWrite) begin
                r_pc <= w_pc_plus2;
            end
            if (!fetchWrite) begin
                r_instr    <= instrIn;
                r_pc_plus2 <= w_pc_plus2;
                r_valid    <= 1'b1;
            end
        end
    end

    // Debug counters: consecutive-hold run with sticky timeout, and total stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_run  <= 8'd0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else if (w_stall) begin
            r_hold_run <= w_hold_run_inc;
            if (w_hold_run_inc == c_MAX_HOLD) begin
                r_timeout <= 1'b1;
            end
            if (r_stall_cnt != c_STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end else begin
            r_hold_run <= 8'd0;
        end
    end

    assign pc          = r_pc;
    assign instrOut    = r_instr;
    assign pcPlus2Out  = r_pc_plus2;
    assign validOut    = r_valid;
    assign state       = r_state;
    assign stallCount  = r_stall_cnt;
    assign holdTimeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_buffer
//  Description : Directed scenarios plus randomized traffic for
//                fetch_decode_buffer, checked against a cycle-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_buffer;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcWrite;
    logic        fetchWrite;
    logic        flush;
    logic [15:0] branchTarget;
    logic [15:0] instrIn;
    logic [15:0] pc;
    logic [15:0] instrOut;
    logic [15:0] pcPlus2Out;
    logic        validOut;
    logic [1:0]  state;
    logic [15:0] stallCount;
    logic        holdTimeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (plain integers)
    int m_pc, m_instr, m_pp2, m_valid, m_state, m_stall, m_run, m_to;

    fetch_decode_buffer #(
        .SIZE     (16),
        .RESET_PC (16'h0000),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcWrite      (pcWrite),
        .fetchWrite   (fetchWrite),
        .flush        (flush),
        .branchTarget (branchTarget),
        .instrIn      (instrIn),
        .pc           (pc),
        .instrOut     (instrOut),
        .pcPlus2Out   (pcPlus2Out),
        .validOut     (validOut),
        .state        (state),
        .stallCount   (stallCount),
        .holdTimeout  (holdTimeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of the behavioural rules to the model.
    task automatic model_update();
        int old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pp2 = 0; m_valid = 0;
            m_state = 0; m_stall = 0; m_run = 0; m_to = 0;
        end else if (flush) begin
            m_pc = int'(branchTarget);
            m_instr = 0; m_pp2 = 0; m_valid = 0;
            m_state = 2;
            m_run = 0;
        end else begin
            if (!pcWrite) m_pc = (old_pc + 2) % 65536;
            if (fetchWrite) begin
                m_state = 1;
                m_run = (m_run < 255) ? m_run + 1 : 255;
                if (m_run == MAX_HOLD) m_to = 1;
                if (m_stall < 65535) m_stall = m_stall + 1;
            end else begin
                m_state = 0;
                m_run = 0;
                m_instr = int'(instrIn);
                m_pp2 = (old_pc + 2) % 65536;
                m_valid = 1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic pw, input logic fw,
                         input logic [15:0] bt, input logic [15:0] ii);
        rst = r; flush = fl; pcWrite = pw; fetchWrite = fw;
        branchTarget = bt; instrIn = ii;
    endtask

    // One clock: edge, settle, advance the model, compare every output.
    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        chk("pc",          32'(pc),          32'(m_pc));
        chk("instrOut",    32'(instrOut),    32'(m_instr));
        chk("pcPlus2Out",  32'(pcPlus2Out),  32'(m_pp2));
        chk("validOut",    32'(validOut),    32'(m_valid));
        chk("state",       32'(state),       32'(m_state));
        chk("stallCount",  32'(stallCount),  32'(m_stall));
        chk("holdTimeout", 32'(holdTimeout), 32'(m_to));
    endtask

    initial begin
        int burst;
        burst = 0;
        m_pc = 0; m_instr = 0; m_pp2 = 0; m_valid = 0;
        m_state = 0; m_stall = 0; m_run = 0; m_to = 0;

        // Reset
        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        step();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_valid", 32'(validOut), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_stall", 32'(stallCount), 32'h0);

        // First fetch after reset
        drive(0, 0, 0, 0, 16'h0000, 16'h1234);
        step();
        chk("first_instr", 32'(instrOut), 32'h1234);
        chk("first_pp2", 32'(pcPlus2Out), 32'h0002);
        chk("first_valid", 32'(validOut), 32'h1);
        chk("first_pc", 32'(pc), 32'h0002);

        // Load-use stall at 0x0010
        drive(0, 1, 0, 0, 16'h0010, 16'h5555);
        step();
        drive(0, 0, 1, 1, 16'h0000, 16'hAAAA);
        step();
        chk("stall1_state", 32'(state), 32'h1);
        chk("stall1_pc", 32'(pc), 32'h0010);
        step();
        chk("stall2_state", 32'(state), 32'h1);
        chk("stall2_pc", 32'(pc), 32'h0010);
        chk("stall2_cnt", 32'(stallCount), 32'h2);
        drive(0, 0, 0, 0, 16'h0000, 16'h7777);
        step();
        chk("unstall_state", 32'(state), 32'h0);
        chk("unstall_pc", 32'(pc), 32'h0012);

        // Flush beats hold
        drive(0, 1, 0, 0, 16'h0020, 16'h0000);
        step();
        drive(0, 1, 1, 1, 16'h0100, 16'h4321);
        step();
        chk("fl_pc", 32'(pc), 32'h0100);
        chk("fl_instr", 32'(instrOut), 32'h0);
        chk("fl_valid", 32'(validOut), 32'h0);
        chk("fl_state", 32'(state), 32'h2);
        chk("fl_stall", 32'(stallCount), 32'h2);
        drive(0, 0, 0, 0, 16'h0000, 16'h9999);
        step();
        chk("postfl_state", 32'(state), 32'h0);
        chk("postfl_valid", 32'(validOut), 32'h1);

        // PC wrap
        drive(0, 1, 0, 0, 16'hFFFE, 16'h0000);
        step();
        drive(0, 0, 0, 0, 16'h0000, 16'h0BAD);
        step();
        chk("wrap_pc", 32'(pc), 32'h0000);
        chk("wrap_pp2", 32'(pcPlus2Out), 32'h0000);

        // Watchdog
        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        step();
        drive(0, 0, 1, 1, 16'h0000, 16'h0000);
        for (int i = 0; i < 7; i++) step();
        chk("wd_7", 32'(holdTimeout), 32'h0);
        step();
        chk("wd_8", 32'(holdTimeout), 32'h1);
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++) step();
        chk("wd_sticky", 32'(holdTimeout), 32'h1);
        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        step();
        chk("wd_rst", 32'(holdTimeout), 32'h0);

        // Randomized traffic with occasional long hold bursts
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(4, 12);
            if (burst > 0) begin
                fetchWrite = 1'b1;
                burst--;
            end else begin
                fetchWrite = ($urandom_range(0, 2) == 0);
            end
            pcWrite = fetchWrite ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            branchTarget = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            instrIn = 16'($urandom);
            step();
        end

        // Stall counter saturation, then reset in the middle of a hold
        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        step();
        drive(0, 0, 1, 1, 16'h0000, 16'h1111);
        for (int i = 0; i < 65540; i++) step();
        chk("sat_stall", 32'(stallCount), 32'hFFFF);
        drive(1, 0, 1, 1, 16'h0000, 16'h1111);
        step();
        chk("midhold_rst_stall", 32'(stallCount), 32'h0);
        chk("midhold_rst_state", 32'(state), 32'h0);
        chk("midhold_rst_to", 32'(holdTimeout), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
